// File: rtl/niosii_system_sysid_reader_pkg.sv
// Shared definitions for the sysid reader: FSM state encoding, Avalon word
// addresses of the sysid slave, timeout counter width and the result compare.
package sysid_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;  // system ID word
  localparam logic ADDR_TS = 1'b1;  // build timestamp word

  localparam int TMO_W = 16;        // timeout counter width

  // True when both captured words equal their expected values.
  function automatic logic words_match(input logic [31:0] id_word,
                                       input logic [31:0] ts_word,
                                       input logic [31:0] exp_id,
                                       input logic [31:0] exp_ts);
    return (id_word == exp_id) && (ts_word == exp_ts);
  endfunction

endpackage

// File: rtl/niosii_system_sysid_reader_if.sv
// Avalon-MM read-only link between the sysid reader (master) and the sysid
// slave. Signals: avm_address (word 0 = ID, 1 = timestamp), avm_read strobe,
// avm_readdata (32-bit) and avm_waitrequest stall from the slave.
interface niosii_system_sysid_reader_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/niosii_system_sysid_reader_timeout_ctr.sv
// Stall watchdog for one read. Ports: clock, reset (sync, active-high),
// clear (zero the count), stall (a read cycle held by waitrequest), limit
// (allowed stalled cycles) and expired (this stall cycle reaches the limit).
module sysid_timeout_ctr
  import sysid_reader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             stall,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  // Next count: clear wins, otherwise count stalls and saturate at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {TMO_W{1'b0}};
    end else if (stall && (count_q != {TMO_W{1'b1}})) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Expired flags the stall cycle that brings the count up to the limit, so
  // the read is held for exactly 'limit' stalled cycles before it is dropped.
  // One extra bit keeps the compare correct at the saturation point.
  assign expired = stall && (({1'b0, count_q} + 17'd1) >= {1'b0, limit});

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {TMO_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/niosii_system_sysid_reader.sv
// Reads the sysid slave's ID (word 0) and timestamp (word 1) on a start pulse
// and compares them with the expected values.
// Ports: clock, reset (sync, active-high), start pulse, avm master link,
// busy, done pulse, sticky pass / timeout_err, captured id_value / ts_value.
module niosii_system_sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h5892_7058,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  niosii_system_sysid_reader_if.master        avm,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                timeout_err,
  output logic [31:0]                         id_value,
  output logic [31:0]                         ts_value
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic        accept_s;
  logic        stall_s;
  logic        expired_s;
  logic        ctr_clear_s;

  assign accept_s = read_q && !avm.avm_waitrequest;
  assign stall_s  = read_q && avm.avm_waitrequest;

  sysid_timeout_ctr u_timeout_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (ctr_clear_s),
    .stall   (stall_s),
    .limit   (TMO_LIMIT),
    .expired (expired_s)
  );

  // Next-state and next-output logic. Outputs are computed for the coming
  // state so that read/address/done/busy all leave registers; read is raised
  // on the start edge, which gives a zero-wait slave back-to-back reads.
  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    id_d        = id_q;
    ts_d        = ts_q;
    ctr_clear_s = 1'b0;
    busy_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RD_ID;
          read_d      = 1'b1;
          addr_d      = ADDR_ID;
          pass_d      = 1'b0;
          tmo_d       = 1'b0;
          ctr_clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ID: begin
        if (accept_s) begin
          state_d     = ST_RD_TS;
          id_d        = avm.avm_readdata;
          addr_d      = ADDR_TS;
          ctr_clear_s = 1'b1;
        end else if (expired_s) begin
          state_d = ST_FINISH;
          read_d  = 1'b0;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RD_ID;
        end
      end
      ST_RD_TS: begin
        if (accept_s) begin
          state_d     = ST_FINISH;
          ts_d        = avm.avm_readdata;
          read_d      = 1'b0;
          done_d      = 1'b1;
          ctr_clear_s = 1'b1;
          // The timestamp is compared straight off the bus on its capture edge.
          pass_d      = words_match(id_q, avm.avm_readdata, EXPECTED_ID, EXPECTED_TS);
        end else if (expired_s) begin
          state_d = ST_FINISH;
          read_d  = 1'b0;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RD_TS;
        end
      end
      ST_FINISH: begin
        // Start is deliberately not looked at here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      addr_q  <= ADDR_ID;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= 32'h0000_0000;
      ts_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout_err     = tmo_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;

endmodule
